uart_cmd_ctrl: RTL and testbench

Frame parser and command sequencer sitting directly behind the UART receiver in the Pong design. Consumes the receiver's one-cycle byte strobes and assembles 4-byte frames: SYNC, CMD, ARG, CKS. Validates each frame and hands it to game logic over a valid/ready handshake. Reports checksum, inter-byte timeout and overrun errors as one-cycle pulses.

---
 rtl/uart_cmd_ctrl_pkg.sv | 30 +++
 rtl/uart_cmd_ctrl_if.sv | 33 +++
 rtl/uart_cmd_ctrl_timeout.sv | 41 ++++
 rtl/uart_cmd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command parser.
// Holds the parser state encoding, the default frame sync marker, the
// ACK/NAK response codes and the Pong game command codes.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_CMD = 2'd1,
        GET_ARG = 2'd2,
        GET_CKS = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [7:0] CMD_P1_UP = 8'h01;
    localparam logic [7:0] CMD_P1_DN = 8'h02;
    localparam logic [7:0] CMD_P2_UP = 8'h03;
    localparam logic [7:0] CMD_P2_DN = 8'h04;
    localparam logic [7:0] CMD_START = 8'h10;
    localparam logic [7:0] CMD_PAUSE = 8'h11;

    // Frame check byte: XOR of command and argument.
    function automatic logic [7:0] frame_cksum(input logic [7:0] cmd, input logic [7:0] arg);
        return cmd ^ arg;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: byte stream in from the UART receiver and the
// command valid/ready handshake out toward game logic.
// Signal directions are named from the parser's point of view.
interface uart_cmd_ctrl_if;

    logic       rx_dv_i;
    logic [7:0] rx_byte_i;
    logic       cmd_valid_o;
    logic       cmd_ready_i;
    logic [7:0] cmd_o;
    logic [7:0] arg_o;

    // The parser side.
    modport slave (
        input  rx_dv_i,
        input  rx_byte_i,
        input  cmd_ready_i,
        output cmd_valid_o,
        output cmd_o,
        output arg_o
    );

    // The side feeding bytes and consuming commands.
    modport master (
        output rx_dv_i,
        output rx_byte_i,
        output cmd_ready_i,
        input  cmd_valid_o,
        input  cmd_o,
        input  arg_o
    );

endinterface

// File: rtl/uart_cmd_ctrl_timeout.sv
// uart_cmd_timeout: inter-byte idle counter for the frame parser.
// Counts enabled cycles since the last clear; tc_o is high while enabled
// and the count sits on its last value (TIMEOUT_CLKS-1).
module uart_cmd_timeout #(
    parameter int TIMEOUT_CLKS = 8680,
    parameter int CNT_W        = 14
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CLKS - 1);

    // Next count: clear wins over counting, hold when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: 4-byte frame parser (SYNC, CMD, ARG, CKS) behind the UART
// receiver. Delivers validated commands through a one-entry output slot
// with valid/ready handshake and reports checksum, timeout and overrun
// errors as registered one-cycle pulses.
// Optional macro UART_CMD_ACK_EN adds an ACK/NAK response path toward a
// UART transmitter (tx_dv_o, tx_byte_o, tx_active_i).
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 8680,
    parameter int         CNT_W        = 14
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    uart_cmd_ctrl_if.slave  bus,
    output logic            err_cksum_o,
    output logic            err_timeout_o,
    output logic            err_overrun_o,
`ifdef UART_CMD_ACK_EN
    output logic            tx_dv_o,
    output logic [7:0]      tx_byte_o,
    input  logic            tx_active_i,
`endif
    output logic            busy_o
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_GET_CMD = GET_CMD;
    localparam logic [1:0] S_GET_ARG = GET_ARG;
    localparam logic [1:0] S_GET_CKS = GET_CKS;

    logic [1:0] state_q, state_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic [7:0] arg_byte_q, arg_byte_d;

    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_out_q, cmd_out_d;
    logic [7:0] arg_out_q, arg_out_d;

    logic err_cksum_q, err_timeout_q, err_overrun_q;

    logic timer_clr, timer_en, timer_tc;
    logic timeout_hit;
    logic frame_done;
    logic cksum_ok;
    logic slot_free;
    logic deliver;
    logic overrun;
    logic cksum_err;

    uart_cmd_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .CNT_W        (CNT_W)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tc_o   (timer_tc)
    );

    // The timer only runs mid-frame and restarts on every received byte;
    // a byte arriving on the terminal cycle suppresses the timeout.
    assign timer_en    = (state_q != S_IDLE);
    assign timer_clr   = bus.rx_dv_i || (state_q == S_IDLE);
    assign timeout_hit = timer_tc && !bus.rx_dv_i;

    // Frame parser state machine and field capture.
    always_comb begin
        state_d    = state_q;
        cmd_byte_d = cmd_byte_q;
        arg_byte_d = arg_byte_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_dv_i && (bus.rx_byte_i == SYNC_BYTE)) begin
                    state_d = S_GET_CMD;
                end
            end
            S_GET_CMD: begin
                if (bus.rx_dv_i) begin
                    cmd_byte_d = bus.rx_byte_i;
                    state_d    = S_GET_ARG;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_ARG: begin
                if (bus.rx_dv_i) begin
                    arg_byte_d = bus.rx_byte_i;
                    state_d    = S_GET_CKS;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_CKS: begin
                if (bus.rx_dv_i) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cksum_ok  = (bus.rx_byte_i == frame_cksum(cmd_byte_q, arg_byte_q));
    assign slot_free = !cmd_valid_q || bus.cmd_ready_i;
    assign deliver   = frame_done && cksum_ok && slot_free;
    assign overrun   = frame_done && cksum_ok && !slot_free;
    assign cksum_err = frame_done && !cksum_ok;

    // Output slot: load on delivery, empty after a transfer, otherwise hold.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_out_d   = cmd_out_q;
        arg_out_d   = arg_out_q;
        if (deliver) begin
            cmd_valid_d = 1'b1;
            cmd_out_d   = cmd_byte_q;
            arg_out_d   = arg_byte_q;
        end else if (cmd_valid_q && bus.cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end
    end

    // State, captured fields, output slot and registered error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cmd_byte_q    <= '0;
            arg_byte_q    <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_out_q     <= '0;
            arg_out_q     <= '0;
            err_cksum_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_byte_q    <= cmd_byte_d;
            arg_byte_q    <= arg_byte_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_out_q     <= cmd_out_d;
            arg_out_q     <= arg_out_d;
            err_cksum_q   <= cksum_err;
            err_timeout_q <= timeout_hit;
            err_overrun_q <= overrun;
        end
    end

    assign bus.cmd_valid_o = cmd_valid_q;
    assign bus.cmd_o       = cmd_out_q;
    assign bus.arg_o       = arg_out_q;
    assign err_cksum_o     = err_cksum_q;
    assign err_timeout_o   = err_timeout_q;
    assign err_overrun_o   = err_overrun_q;
    assign busy_o          = (state_q != S_IDLE);

`ifdef UART_CMD_ACK_EN
    logic       resp_valid;
    logic [7:0] resp_byte;
    logic       pend_q;
    logic [7:0] pend_byte_q;
    logic       tx_dv_q;
    logic [7:0] tx_byte_q;

    assign resp_valid = deliver || overrun || cksum_err;
    assign resp_byte  = deliver ? ACK_BYTE : NAK_BYTE;

    // One-entry response buffer; a new response overwrites any pending one,
    // and a pending one is issued as a single strobe once the transmitter is idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            if (pend_q && !tx_active_i) begin
                tx_dv_q   <= 1'b1;
                tx_byte_q <= pend_byte_q;
            end
            if (resp_valid) begin
                pend_q      <= 1'b1;
                pend_byte_q <= resp_byte;
            end else if (pend_q && !tx_active_i) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign tx_dv_o   = tx_dv_q;
    assign tx_byte_o = tx_byte_q;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: self-checking bench for uart_cmd_ctrl.
// A frame-level reference model (byte position, timestamp of last byte,
// one output slot) predicts every output each cycle; table vectors and
// hand-written sequences add explicit expected values on top.
module tb_uart_cmd_ctrl;

    localparam int         TO   = 64;
    localparam int         CW   = 7;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst_n;
    logic err_cksum, err_timeout, err_overrun, busy;

    uart_cmd_ctrl_if bus();

`ifdef UART_CMD_ACK_EN
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active = 1'b0;
`endif

    uart_cmd_ctrl #(
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (TO),
        .CNT_W        (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .err_cksum_o   (err_cksum),
        .err_timeout_o (err_timeout),
        .err_overrun_o (err_overrun),
`ifdef UART_CMD_ACK_EN
        .tx_dv_o       (tx_dv),
        .tx_byte_o     (tx_byte),
        .tx_active_i   (tx_active),
`endif
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    // Reference model state
    int         pos;
    logic [7:0] fr [4];
    int         lastT;
    logic       mValid;
    logic [7:0] mCmd, mArg;
    logic       mCk, mTo, mOv;

    typedef struct {
        logic [31:0] frame;
        logic        ready;
        logic        expValid;
        logic [7:0]  expCmd;
        logic [7:0]  expArg;
        logic        expCk;
        logic        expOv;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        pos    = 0;
        lastT  = 0;
        mValid = 1'b0;
        mCmd   = 8'h00;
        mArg   = 8'h00;
        mCk    = 1'b0;
        mTo    = 1'b0;
        mOv    = 1'b0;
    endtask

    // Advance the frame model by one clock with the inputs seen at that edge.
    task automatic modelStep(input logic dv, input logic [7:0] b, input logic rdy);
        logic slotFree, xfer, dlv;
        slotFree = !mValid || rdy;
        xfer     = mValid && rdy;
        dlv      = 1'b0;
        mCk      = 1'b0;
        mTo      = 1'b0;
        mOv      = 1'b0;
        if (pos == 0) begin
            if (dv && b == SYNC) begin
                pos   = 1;
                lastT = cyc;
            end
        end else if (dv) begin
            lastT   = cyc;
            fr[pos] = b;
            if (pos == 3) begin
                pos = 0;
                if (b == (fr[1] ^ fr[2])) begin
                    if (slotFree) dlv = 1'b1;
                    else          mOv = 1'b1;
                end else begin
                    mCk = 1'b1;
                end
            end else begin
                pos++;
            end
        end else if (cyc - lastT == TO) begin
            mTo = 1'b1;
            pos = 0;
        end
        if (dlv) begin
            mValid = 1'b1;
            mCmd   = fr[1];
            mArg   = fr[2];
        end else if (xfer) begin
            mValid = 1'b0;
        end
    endtask

    task automatic modelCompare();
        checkOutput("busy", 32'(busy), 32'(pos != 0));
        checkOutput("cmd_valid", 32'(bus.cmd_valid_o), 32'(mValid));
        checkOutput("err_cksum", 32'(err_cksum), 32'(mCk));
        checkOutput("err_timeout", 32'(err_timeout), 32'(mTo));
        checkOutput("err_overrun", 32'(err_overrun), 32'(mOv));
        if (mValid) begin
            checkOutput("cmd", 32'(bus.cmd_o), 32'(mCmd));
            checkOutput("arg", 32'(bus.arg_o), 32'(mArg));
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, compare 1ns later.
    task automatic applyStimulus(input logic dv, input logic [7:0] b, input logic rdy);
        bus.rx_dv_i     = dv;
        bus.rx_byte_i   = b;
        bus.cmd_ready_i = rdy;
        @(posedge clk);
        if (!rst_n) modelReset();
        else        modelStep(dv, b, rdy);
        cyc++;
        #1;
        modelCompare();
    endtask

    task automatic sendFrame(input logic [31:0] fw, input int gap, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, fw[31-8*i -: 8], rdy);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00, rdy);
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy);
    endtask

    initial begin
        logic [7:0] rb [4];
        int         gap;

        vecs[0] = '{32'hA5011011, 1'b1, 1'b1, 8'h01, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{32'hA5020300, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{32'hA5070007, 1'b1, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{32'hA5A5A500, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[4] = '{32'hA5030406, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{32'hA5040501, 1'b0, 1'b1, 8'h04, 8'h05, 1'b0, 1'b0};
        vecs[6] = '{32'hA5020406, 1'b1, 1'b1, 8'h02, 8'h04, 1'b0, 1'b0};

        bus.rx_dv_i     = 1'b0;
        bus.rx_byte_i   = 8'h00;
        bus.cmd_ready_i = 1'b0;
        rst_n           = 1'b0;
        modelReset();
        #2;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset valid", 32'(bus.cmd_valid_o), 32'd0);
        checkOutput("reset cmd", 32'(bus.cmd_o), 32'd0);
        checkOutput("reset errs", 32'({err_cksum, err_timeout, err_overrun}), 32'd0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        idle(2, 1'b1);

        $display("[TB] table vectors");
        for (int v = 0; v < 7; v++) begin
            sendFrame(vecs[v].frame, 1, vecs[v].ready);
            checkOutput($sformatf("vec%0d valid", v), 32'(bus.cmd_valid_o), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d cksum", v), 32'(err_cksum), 32'(vecs[v].expCk));
            checkOutput($sformatf("vec%0d overrun", v), 32'(err_overrun), 32'(vecs[v].expOv));
            checkOutput($sformatf("vec%0d busy", v), 32'(busy), 32'd0);
            if (vecs[v].expValid) begin
                checkOutput($sformatf("vec%0d cmd", v), 32'(bus.cmd_o), 32'(vecs[v].expCmd));
                checkOutput($sformatf("vec%0d arg", v), 32'(bus.arg_o), 32'(vecs[v].expArg));
            end
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("vec%0d drained", v), 32'(bus.cmd_valid_o), 32'd0);
            checkOutput($sformatf("vec%0d pulse end", v), 32'({err_cksum, err_overrun}), 32'd0);
            idle(2, 1'b1);
        end

        $display("[TB] timeout at terminal count");
        applyStimulus(1'b1, SYNC, 1'b1);
        applyStimulus(1'b1, 8'h01, 1'b1);
        idle(TO - 1, 1'b1);
        checkOutput("to pre busy", 32'(busy), 32'd1);
        checkOutput("to pre pulse", 32'(err_timeout), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("to pulse", 32'(err_timeout), 32'd1);
        checkOutput("to busy drop", 32'(busy), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("to pulse end", 32'(err_timeout), 32'd0);
        sendFrame(32'hA5070007, 0, 1'b1);
        checkOutput("after to valid", 32'(bus.cmd_valid_o), 32'd1);
        checkOutput("after to cmd", 32'(bus.cmd_o), 32'h07);
        idle(2, 1'b1);

        $display("[TB] byte on terminal cycle");
        applyStimulus(1'b1, SYNC, 1'b1);
        applyStimulus(1'b1, 8'h01, 1'b1);
        idle(TO - 1, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b1);
        checkOutput("tc byte no to", 32'(err_timeout), 32'd0);
        checkOutput("tc byte busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 8'h03, 1'b1);
        checkOutput("tc byte valid", 32'(bus.cmd_valid_o), 32'd1);
        checkOutput("tc byte arg", 32'(bus.arg_o), 32'h02);
        idle(2, 1'b1);

        $display("[TB] overrun");
        sendFrame(32'hA5010203, 1, 1'b0);
        sendFrame(32'hA5040501, 1, 1'b0);
        checkOutput("ovr pulse", 32'(err_overrun), 32'd1);
        checkOutput("ovr held cmd", 32'(bus.cmd_o), 32'h01);
        checkOutput("ovr held arg", 32'(bus.arg_o), 32'h02);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ovr stable", 32'(bus.cmd_valid_o), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ovr transfer", 32'(bus.cmd_valid_o), 32'd0);
        idle(2, 1'b1);

        $display("[TB] leading garbage");
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkOutput("garbage busy", 32'(busy), 32'd0);
        sendFrame(32'hA5100010, 2, 1'b1);
        checkOutput("start cmd", 32'(bus.cmd_o), 32'h10);
        checkOutput("start valid", 32'(bus.cmd_valid_o), 32'd1);
        idle(2, 1'b1);

        $display("[TB] async reset mid-frame");
        sendFrame(32'hA5030407, 0, 1'b0);
        applyStimulus(1'b1, SYNC, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("arst busy", 32'(busy), 32'd0);
        checkOutput("arst valid", 32'(bus.cmd_valid_o), 32'd0);
        checkOutput("arst cmd", 32'(bus.cmd_o), 32'd0);
        checkOutput("arst arg", 32'(bus.arg_o), 32'd0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        sendFrame(32'hA5110011, 1, 1'b1);
        checkOutput("pause cmd", 32'(bus.cmd_o), 32'h11);
        checkOutput("pause arg", 32'(bus.arg_o), 32'h00);
        idle(2, 1'b1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 5) == 0) applyStimulus(1'b1, 8'($urandom), 1'($urandom_range(0, 3) != 0));
            rb[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : SYNC;
            rb[1] = 8'($urandom);
            rb[2] = 8'($urandom);
            rb[3] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (rb[1] ^ rb[2]);
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, rb[i], 1'($urandom_range(0, 3) != 0));
                if (i < 3) begin
                    gap = ($urandom_range(0, 14) == 0) ? (TO - 2 + int'($urandom_range(0, 3)))
                                                       : int'($urandom_range(0, 3));
                    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00, 1'($urandom_range(0, 3) != 0));
                end
            end
            idle(int'($urandom_range(0, 5)), 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
